// File: rtl/matrix_stream_fifo.sv
// Width-converting FIFO: stores whole DDR words and pops LanesOut-cell slices, LSB slice first.
// Optional replay mode (MATRIX_FIFO_REPLAY_EN) retains consumed words until mark_i releases them.
module matrix_stream_fifo #(
  parameter int DataWidth = 512,
  parameter int CellWidth = 2,
  parameter int LanesOut  = 8,
  parameter int Depth     = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [DataWidth-1:0]                 data_i,
  input  logic                                 push_i,
  output logic                                 full_o,
  input  logic                                 pop_i,
  output logic                                 valid_o,
  output logic [LanesOut*CellWidth-1:0]        data_o,
  output logic [$clog2(Depth+1)-1:0]           count_o,
  input  logic                                 mark_i,
  input  logic                                 rewind_i
);
  localparam int SliceW = LanesOut * CellWidth;
  localparam int Slices = DataWidth / SliceW;
  localparam int AddrW  = $clog2(Depth);
  localparam int PtrW   = AddrW + 1;
  localparam int CntW   = $clog2(Depth + 1);
  localparam int SlW    = (Slices > 1) ? $clog2(Slices) : 1;

  if (Slices < 2 || Slices * SliceW != DataWidth || Depth < 2 || (Depth & (Depth - 1)) != 0)
  begin : g_bad_cfg
    $error("matrix_stream_fifo: illegal DataWidth/SliceW/Depth combination");
  end

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_q, wr_d;
  logic [PtrW-1:0]      rd_q, rd_d;
  logic [SlW-1:0]       slice_q, slice_d;
  logic [PtrW-1:0]      mark_ptr;
  logic                 push_ok, pop_ok, do_mark, do_rewind;
  logic [DataWidth-1:0] rd_word, rd_shift;
  logic [PtrW-1:0]      held;

`ifdef MATRIX_FIFO_REPLAY_EN
  logic [PtrW-1:0] mark_q, mark_d;
  assign mark_ptr  = mark_q;
  assign do_mark   = mark_i;
  assign do_rewind = rewind_i;
`else
  logic unused_replay_in;
  assign unused_replay_in = mark_i ^ rewind_i;
  assign mark_ptr  = rd_q;
  assign do_mark   = 1'b0;
  assign do_rewind = 1'b0;
`endif

  // Status decodes registered pointers only, so a same-cycle pop never unblocks a push.
  always_comb begin
    held     = wr_q - mark_ptr;
    count_o  = CntW'(held);
    full_o   = (count_o == CntW'(Depth));
    valid_o  = (wr_q != rd_q);
    rd_word  = mem_q[rd_q[AddrW-1:0]];
    rd_shift = rd_word >> (int'(slice_q) * SliceW);
    data_o   = valid_o ? rd_shift[SliceW-1:0] : '0;
  end

  always_comb begin
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && valid_o && !do_rewind;
    wr_d    = push_ok ? wr_q + PtrW'(1) : wr_q;
    rd_d    = rd_q;
    slice_d = slice_q;
    if (do_rewind) begin
      rd_d    = mark_ptr;
      slice_d = '0;
    end else if (pop_ok) begin
      if (slice_q == SlW'(Slices - 1)) begin
        slice_d = '0;
        rd_d    = rd_q + PtrW'(1);
      end else begin
        slice_d = slice_q + SlW'(1);
      end
    end
  end

`ifdef MATRIX_FIFO_REPLAY_EN
  // Mark captures the read pointer as it was before this cycle's pop.
  always_comb begin
    mark_d = mark_q;
    if (do_mark && !do_rewind) mark_d = rd_q;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      slice_q <= '0;
`ifdef MATRIX_FIFO_REPLAY_EN
      mark_q  <= '0;
`endif
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      slice_q <= slice_d;
`ifdef MATRIX_FIFO_REPLAY_EN
      mark_q  <= mark_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AddrW-1:0]] <= data_i;
  end
endmodule

// File: tb/tb_matrix_stream_fifo.sv
// Scoreboard bench for matrix_stream_fifo at DataWidth=16, SliceW=4, Depth=2.
// Build with +define+MATRIX_FIFO_REPLAY_EN to exercise the replay expectations.
module tb_matrix_stream_fifo;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   data_i;
  logic          push_i, pop_i, mark_i, rewind_i;
  logic          full_o, valid_o;
  logic [W-1:0]  data_o;
  logic [1:0]    count_o;

  logic [W-1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  matrix_stream_fifo #(.DataWidth(16), .CellWidth(2), .LanesOut(2), .Depth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .push_i(push_i), .full_o(full_o),
    .pop_i(pop_i), .valid_o(valid_o), .data_o(data_o), .count_o(count_o),
    .mark_i(mark_i), .rewind_i(rewind_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted pop must match the next expected slice.
  always @(negedge clk) begin
    if (rst_n && pop_i && valid_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_slice: got %h but no slice was expected", data_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          n_err++;
          $display("FAIL pop_slice: got %h expected %h", data_o, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic push, input logic [15:0] d, input logic pop,
                      input logic mark, input logic rew);
    push_i = push; data_i = d; pop_i = pop; mark_i = mark; rewind_i = rew;
    @(posedge clk); #1;
    push_i = 1'b0; pop_i = 1'b0; mark_i = 1'b0; rewind_i = 1'b0; data_i = '0;
  endtask

  task automatic push_w(input logic [15:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_s(input logic [W-1:0] e);
    exp_q.push_back(e);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_word(input logic [15:0] w);
    for (int i = 0; i < 4; i++) pop_s(w[i*4 +: 4]);
  endtask

  // Replay builds retain consumed words until a mark releases them.
  task automatic release_words();
`ifdef MATRIX_FIFO_REPLAY_EN
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
`endif
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, valid_o, 1'b0);
    check({tag, "_data"},  data_o,  4'h0);
    check({tag, "_count"}, count_o, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    push_i = 1'b0; pop_i = 1'b0; mark_i = 1'b0; rewind_i = 1'b0; data_i = '0;
    #12;
    check("rst_full", full_o, 1'b0);
    check_empty("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Scenario 1: first-word fall-through and LSB-first slicing
    push_w(16'hA5C3);
    check("s1_valid", valid_o, 1'b1);
    check("s1_data",  data_o,  4'h3);
    check("s1_count", count_o, 2'd1);
    pop_s(4'h3); pop_s(4'hC); pop_s(4'h5); pop_s(4'hA);
    release_words();
    check_empty("s1_end");

    // Scenario 2: third push dropped while full
    push_w(16'h1111);
    push_w(16'h2222);
    check("s2_full2", full_o, 1'b1);
    push_w(16'h3333);
    check("s2_full3",  full_o,  1'b1);
    check("s2_count3", count_o, 2'd2);
    pop_word(16'h1111);
    release_words();
    check("s2_full_clr", full_o,  1'b0);
    check("s2_count1",   count_o, 2'd1);
    pop_word(16'h2222);
    release_words();
    check_empty("s2_end");

    // Scenario 3: pop on empty, then push+pop on empty
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_empty("s3_pop_empty");
    step(1'b1, 16'h6789, 1'b1, 1'b0, 1'b0);
    check("s3_valid", valid_o, 1'b1);
    check("s3_data",  data_o,  4'h9);
    check("s3_count", count_o, 2'd1);
    pop_word(16'h6789);
    release_words();
    check_empty("s3_end");

    // Scenario 4: last-slice pop and push in the same cycle
    push_w(16'h4321);
    pop_s(4'h1); pop_s(4'h2); pop_s(4'h3);
    check("s4_count_pre", count_o, 2'd1);
    exp_q.push_back(4'h4);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
`ifdef MATRIX_FIFO_REPLAY_EN
    check("s4_count_retained", count_o, 2'd2);
    release_words();
`endif
    check("s4_count", count_o, 2'd1);
    check("s4_data",  data_o,  4'hF);
    check("s4_full",  full_o,  1'b0);
    pop_word(16'hBEEF);
    release_words();
    check_empty("s4_end");

    // Scenario 5: mark / rewind
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    push_w(16'h1234);
    pop_word(16'h1234);
    check("s5_valid", valid_o, 1'b0);
`ifdef MATRIX_FIFO_REPLAY_EN
    check("s5_count", count_o, 2'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("s5_rew_valid", valid_o, 1'b1);
    check("s5_rew_data",  data_o,  4'h4);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("s5_mark_count", count_o, 2'd1);
    pop_word(16'h1234);
    release_words();
    check_empty("s5_end");
`else
    check("s5_count", count_o, 2'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_empty("s5_rew");
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("s5_mark_count", count_o, 2'd0);
`endif

    // Scenario 6: asynchronous reset while full
    push_w(16'h1111);
    push_w(16'h2222);
    check("s6_full", full_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_full", full_o, 1'b0);
    check_empty("s6_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_w(16'hA5C3);
    check("s6_valid", valid_o, 1'b1);
    check("s6_data",  data_o,  4'h3);
    check("s6_count", count_o, 2'd1);
    pop_word(16'hA5C3);
    release_words();
    check_empty("s6_end");

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/matrix_stream_fifo.md
# matrix_stream_fifo

Parametrised width-converting FIFO between the DDR read path and the ternary matmul datapath. Stores whole DDR words and returns them as slices of `LanesOut` ternary cells per pop, so downstream lanes consume several cells per cycle. Depth and slice width are configurable. An optional replay mode keeps consumed words resident so a matrix row can be streamed again without refetching from DDR.

## Interface
- `DataWidth`, default 512: push word width in bits (`DdrDataWidth`).
- `CellWidth`, default 2: bits per cell (`$bits(ternary_t)`).
- `LanesOut`, default 8: cells per popped slice; `SliceW = LanesOut*CellWidth`.
- `Depth`, default 4: storage in words, power of two, ≥2.
- Derived: `Slices = DataWidth/SliceW`, an integer ≥2; elaboration fails otherwise.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `data_i` in DataWidth: word to push.
- `push_i` in 1: push request.
- `full_o` out 1: no free word.
- `pop_i` in 1: pop request.
- `valid_o` out 1: `data_o` holds a slice.
- `data_o` out SliceW: current slice; 0 when `valid_o`=0.
- `count_o` out $clog2(Depth+1): words held, including retained words.
- `mark_i` in 1: replay mark (replay only).
- `rewind_i` in 1: replay rewind (replay only).

## Operation
- State: `wr_ptr`, `rd_ptr`, `mark_ptr`, each $clog2(Depth)+1 bits with a wrap bit, plus `slice_idx` (0..Slices-1). Storage array is not reset.
- Push is accepted when `push_i && !full_o`. It writes `mem[wr_ptr]` and increments `wr_ptr`. A push while full is dropped with no state change.
- Pop is accepted when `pop_i && valid_o`. If `slice_idx` < Slices-1, `slice_idx` increments. Otherwise `slice_idx` returns to 0 and `rd_ptr` increments. A pop while empty is ignored.
- `data_o = mem[rd_ptr][slice_idx*SliceW +: SliceW]`. Slice 0 is the LSBs.
- `valid_o = (wr_ptr != rd_ptr)`.
- `count_o = wr_ptr - mark_ptr`.
- `full_o = (count_o == Depth)`.
- Without replay, `mark_ptr` is identical to `rd_ptr`.
- Replay:
  - `mark_i` sets `mark_ptr` to the pre-update `rd_ptr`. This releases all fully consumed words.
  - `rewind_i` sets `rd_ptr` to `mark_ptr` and `slice_idx` to 0.
  - Words between `mark_ptr` and `rd_ptr` are retained and still count toward `full_o`.
- Priority: `rewind_i` beats `pop_i` and `mark_i` in the same cycle; the pop and the mark are ignored. Push is independent of rewind and mark.
- Push and pop in the same cycle are both applied when each is individually legal. A pop that frees a word does not unblock a same-cycle push while full; `full_o` is evaluated from registered state.
- Reset, including mid-operation, discards all contents: every pointer and `slice_idx` returns to 0.

## Timing
- Reset values: `full_o`=0, `valid_o`=0, `data_o`=0, `count_o`=0.
- All outputs decode registered state only. There is no combinational path from input to output.
- Push to `valid_o`: 1 cycle. A word pushed at edge N is visible after edge N (first-word fall-through).
- Each accepted pop shows the next slice after the following edge, giving one slice per cycle at full rate.
- The last-slice pop at edge N clears `full_o` and decrements `count_o` after edge N. In replay mode, the decrement waits for `mark_i` instead.
- Rewind at edge N: the slice at `mark_ptr`, slice 0, is on `data_o` after edge N.

## Configuration
- `MATRIX_FIFO_REPLAY_EN`
  - Defined: `mark_ptr` is an independent register and `mark_i`/`rewind_i` act as described above.
  - Undefined: `mark_ptr` is tied to `rd_ptr` and `mark_i`/`rewind_i` are ignored. The ports remain present so the interface is identical.

## Test plan
Parameters for all scenarios: DataWidth=16, CellWidth=2, LanesOut=2, Depth=2 (SliceW=4, Slices=4).
1. Reset, then push 16'hA5C3 → the next cycle shows `valid_o`=1, `data_o`=4'h3, `count_o`=1. Four pops yield 3, C, 5, A. After the 4th pop, `valid_o`=0, `data_o`=0, `count_o`=0.
2. Push 16'h1111, 16'h2222, 16'h3333 back-to-back → the third push is dropped, `full_o`=1, `count_o`=2. Four pops give 1,1,1,1, then `full_o`=0. The next four pops give 2s.
3. Pop on empty → no state change, `data_o`=0. A push and a pop on empty in the same cycle → the push is accepted, the pop is ignored, and `data_o`=slice 0 next cycle.
4. `count_o`=1 on slice 3, then a pop plus a push of 16'hBEEF → `count_o` stays 1 and `data_o`=4'hF.
5. Replay defined: `mark_i`, push 16'h1234, then four pops (4,3,2,1) → `valid_o`=0, `count_o`=1. `rewind_i` → `data_o`=4'h4 again. `mark_i` after rewind with no pops → `count_o` stays 1. Macro undefined: the same sequence leaves `count_o`=0 and rewind has no effect.
6. Assert `rst_ni` low mid-stream with `full_o`=1 → `valid_o`, `full_o` and `count_o` go to 0 immediately, without waiting for a clock edge. After release, a fresh push behaves as in scenario 1.
